run_monitor: RTL
================

// Module: run_monitor
// PURPOSE
//   Parametrised end-of-run monitor for the pipelined processor; generalises the fixed
//   cycle counter and four hard-wired result checks. Counts run cycles and retired
//   instructions from the write-back stage, detects the halt opcode, then compares
//   NCHK watched values against expected values. Streams one pass/fail character per
//   check, plus a summary character, to the OLED display write port with a ready handshake.
// PARAMETERS
//   NCHK       4          number of watched value/expected pairs (1..16)
//   DW         32         width of each watched value
//   CW         32         width of cycle and retire counters
//   HALT_OP    6'b111111  opcode that ends the run when seen in write-back
//   AW         6          display write-address width
//   BASE_ADDR  6'd0       display address of the first check character
//   PASS_CHAR  8'h2B      '+' ; FAIL_CHAR 8'h2D '-' ; IDLE_CHAR 8'h2C ','
// PORTS
//   sysclk      in   1        system clock, rising edge
//   cpu_resetn  in   1        asynchronous active-low reset
//   op_w        in   6        opcode in write-back stage
//   wb_valid    in   1        write-back stage holds a real (non-bubble) instruction
//   chk_val     in   NCHK*DW  watched values; check i = chk_val[i*DW +: DW]
//   chk_exp     in   NCHK*DW  expected values, same packing
//   disp_ready  in   1        display accepts the write presented this cycle
//   disp_we     out  1        display write strobe
//   disp_addr   out  AW       display write address
//   disp_data   out  8        display character
//   run_cycles  out  CW       cycles from reset release to halt, inclusive
//   retired     out  CW       instructions retired, halt included
//   pass_mask   out  NCHK     bit i = check i passed (valid when halted)
//   all_pass    out  1        &pass_mask (valid when halted)
//   halted      out  1        high once all characters are emitted
// BEHAVIOUR
//   - Reset (async, any state): state=RUN; counters=0; pass_mask=0; all_pass=0;
//     halted=0; disp_we=0; disp_addr=BASE_ADDR; disp_data=IDLE_CHAR; idx=0.
//   - RUN: run_cycles +1 every cycle; retired +1 when wb_valid. Both saturate at
//     all-ones and never wrap. A wb_valid with op_w==HALT_OP counts in both
//     counters that same cycle (matches total_count = count+1); next state SNAP.
//     op_w==HALT_OP with wb_valid=0 is a bubble and is ignored.
//   - SNAP (1 cycle): pass_mask[i] <= (chk_val[i]==chk_exp[i]), full DW compare;
//     all_pass <= &compare; counters frozen from here on; next state EMIT, idx=0.
//   - EMIT: disp_we=1, disp_addr=BASE_ADDR+idx (mod 2^AW),
//     disp_data = pass_mask[idx] ? PASS_CHAR : FAIL_CHAR for idx<NCHK;
//     for idx==NCHK: summary, all_pass ? PASS_CHAR : FAIL_CHAR.
//     Address, data and strobe hold steady until a cycle with disp_ready=1, which
//     completes the write; idx advances next cycle. After the summary write
//     completes -> DONE. disp_ready has no effect outside EMIT.
//   - DONE: disp_we=0, halted=1; all outputs hold; further halts ignored.
//     Leave DONE only by reset.
//   - Reset asserted mid-EMIT aborts the stream immediately; no partial retry.
//   - All outputs registered; chk_val/chk_exp sampled only in SNAP.
// TESTING
//   1 Reset, 9 cycles wb_valid=1 op!=HALT, then HALT (wb_valid=1) -> run_cycles=10,
//     retired=10; writes at addr 0..4, all '+' when chk_val==chk_exp; halted=1.
//   2 Bubbles: 3 cycles wb_valid=0 among 6 -> retired=run_cycles-3; op_w=HALT_OP
//     with wb_valid=0 -> no halt.
//   3 chk_exp[2] differs by bit 31 only -> pass_mask=4'b1011, addr 2 '-', addr 4 '-'.
//   4 disp_ready low 3 cycles on the first write -> disp_we/addr/data stable, exactly
//     NCHK+1 accepted writes total.
//   5 BASE_ADDR=6'd62, NCHK=4 -> write addrs 62,63,0,1,2 (wrap); CW=4 with 20-cycle
//     run -> run_cycles=15 (saturated).
//   6 cpu_resetn low during EMIT (idx=2) -> disp_we=0, counters=0, state RUN;
//     a new run completes normally.

Source files
------------

// File: rtl/run_monitor.sv
// End-of-run monitor: counts cycles and retired instructions until halt,
// checks watched values and streams pass/fail characters to the display.
module run_monitor #(
    parameter int            NCHK      = 4,
    parameter int            DW        = 32,
    parameter int            CW        = 32,
    parameter logic [5:0]    HALT_OP   = 6'b111111,
    parameter int            AW        = 6,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter logic [7:0]    PASS_CHAR = 8'h2B,
    parameter logic [7:0]    FAIL_CHAR = 8'h2D,
    parameter logic [7:0]    IDLE_CHAR = 8'h2C
) (
    input  logic             sysclk,
    input  logic             cpu_resetn,
    input  logic [5:0]       op_w,
    input  logic             wb_valid,
    input  logic [NCHK*DW-1:0] chk_val,
    input  logic [NCHK*DW-1:0] chk_exp,
    input  logic             disp_ready,
    output logic             disp_we,
    output logic [AW-1:0]    disp_addr,
    output logic [7:0]       disp_data,
    output logic [CW-1:0]    run_cycles,
    output logic [CW-1:0]    retired,
    output logic [NCHK-1:0]  pass_mask,
    output logic             all_pass,
    output logic             halted
);

    // idx runs 0..NCHK; NCHK is the summary slot
    localparam int IW = $clog2(NCHK + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_SNAP,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state_q, state_n;
    logic [IW-1:0]   idx_q, idx_n, idx_inc;
    logic [CW-1:0]   cyc_q, cyc_n;
    logic [CW-1:0]   ret_q, ret_n;
    logic [NCHK-1:0] mask_q, mask_n;
    logic            allp_q, allp_n;
    logic            we_q, we_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [7:0]      data_q, data_n;
    logic            halt_q, halt_n;
    logic [NCHK-1:0] cmp;
    logic            sel_pass;
    logic            halt_seen;

    assign idx_inc   = idx_q + IW'(1);
    assign halt_seen = wb_valid && (op_w == HALT_OP);

    // Full-width equality of each watched value against its expectation
    always_comb begin
        cmp = '0;
        for (int i = 0; i < NCHK; i++) begin
            cmp[i] = (chk_val[i*DW +: DW] == chk_exp[i*DW +: DW]);
        end
    end

    // Verdict for the slot after the current one; summary slot uses all_pass
    always_comb begin
        sel_pass = allp_q;
        for (int i = 0; i < NCHK; i++) begin
            if (idx_inc == IW'(i)) begin
                sel_pass = mask_q[i];
            end
        end
    end

    // Next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        cyc_n   = cyc_q;
        ret_n   = ret_q;
        mask_n  = mask_q;
        allp_n  = allp_q;
        we_n    = we_q;
        addr_n  = addr_q;
        data_n  = data_q;
        halt_n  = halt_q;
        unique case (state_q)
            S_RUN: begin
                if (cyc_q != '1) begin
                    cyc_n = cyc_q + CW'(1);
                end
                if (wb_valid && (ret_q != '1)) begin
                    ret_n = ret_q + CW'(1);
                end
                if (halt_seen) begin
                    state_n = S_SNAP;
                end
            end
            S_SNAP: begin
                mask_n  = cmp;
                allp_n  = &cmp;
                idx_n   = '0;
                we_n    = 1'b1;
                addr_n  = BASE_ADDR;
                data_n  = cmp[0] ? PASS_CHAR : FAIL_CHAR;
                state_n = S_EMIT;
            end
            S_EMIT: begin
                if (disp_ready) begin
                    if (idx_q == IW'(NCHK)) begin
                        we_n    = 1'b0;
                        halt_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        idx_n  = idx_inc;
                        addr_n = BASE_ADDR + AW'(idx_inc);
                        data_n = sel_pass ? PASS_CHAR : FAIL_CHAR;
                    end
                end
            end
            S_DONE: begin
                we_n = 1'b0;
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run or stream at once
    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
            mask_q  <= '0;
            allp_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= IDLE_CHAR;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cyc_q   <= cyc_n;
            ret_q   <= ret_n;
            mask_q  <= mask_n;
            allp_q  <= allp_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            halt_q  <= halt_n;
        end
    end

    assign disp_we    = we_q;
    assign disp_addr  = addr_q;
    assign disp_data  = data_q;
    assign run_cycles = cyc_q;
    assign retired    = ret_q;
    assign pass_mask  = mask_q;
    assign all_pass   = allp_q;
    assign halted     = halt_q;

endmodule
